// File: rtl/write_back_regfile_if.sv
// Write-back stage bundle: MEM/WB load inputs, pipeline controls, decode read ports, status.
// Latency: n/a (signal bundle only).
// Backpressure: stall/flush travel with the bundle; there is no ready signal.
//
// Modports:
//   master - memory stage / decode / hazard side: drives loads, controls and read indices.
//   slave  - write_back_regfile: drives read data, wb_valid and retire_count.
interface write_back_regfile_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            in_valid;
  logic            RegWrite;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] wd;
  logic            stall;
  logic            flush;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic            wb_valid;
  logic [63:0]     retire_count;

  modport master (
    output in_valid, RegWrite, rd, wd, stall, flush, rs1, rs2,
    input  read_data1, read_data2, wb_valid, retire_count
  );

  modport slave (
    input  in_valid, RegWrite, rd, wd, stall, flush, rs1, rs2,
    output read_data1, read_data2, wb_valid, retire_count
  );
endinterface

// File: rtl/write_back_regfile.sv
// MEM/WB stage register feeding a 32 x XLEN register file, retire counter and two read ports.
// Latency: wd sampled at edge N is committed at edge N+1; reads are combinational.
// Backpressure: stall holds MEM/WB and blocks commit; flush kills the entry (flush wins).
//
// Ports: clk, rst (async active-high); bus (write_back_regfile_if.slave) carries
//   in_valid/RegWrite/rd/wd, stall/flush, rs1/rs2 -> read_data1/read_data2, wb_valid, retire_count.
// Option: define WB_BYPASS_EN for write-first reads of the entry committing this cycle;
//   without it reads return the stored (old) register value.
module write_back_regfile #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  write_back_regfile_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  // MEM/WB stage register
  logic            wb_valid;
  logic            wb_regwrite;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  logic [XLEN-1:0] regs [NREGS];
  logic [63:0]     retire_count;

  logic commit;
  logic wr_en;
  logic hit1;
  logic hit2;

  // The entry retires only if it is neither held nor killed on this edge.
  assign commit = wb_valid && !bus.stall && !bus.flush;
  assign wr_en  = commit && wb_regwrite && (wb_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else if (bus.flush) begin
      wb_valid    <= 1'b0;
    end else if (!bus.stall) begin
      wb_valid    <= bus.in_valid;
      wb_regwrite <= bus.RegWrite;
      wb_rd       <= bus.rd;
      wb_data     <= bus.wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_count <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      // x0 writes are dropped by wr_en but still counted here.
      if (commit) retire_count <= retire_count + 64'd1;
      if (wr_en)  regs[wb_rd]  <= wb_data;
    end
  end

`ifdef WB_BYPASS_EN
  // Write-first: decode sees the value being committed on the coming edge.
  assign hit1 = wr_en && (wb_rd == bus.rs1);
  assign hit2 = wr_en && (wb_rd == bus.rs2);
`else
  // Read-old: hazard logic must cover RAW distance 1 with a stall.
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign bus.read_data1   = (bus.rs1 == '0) ? '0 : hit1 ? wb_data : regs[bus.rs1];
  assign bus.read_data2   = (bus.rs2 == '0) ? '0 : hit2 ? wb_data : regs[bus.rs2];
  assign bus.wb_valid     = wb_valid;
  assign bus.retire_count = retire_count;
endmodule

// File: tb/tb_write_back_regfile.sv
// Bench for write_back_regfile: directed scenarios then random traffic against a reference model.
// Latency: model commits the pending instruction one edge after it is captured.
// Backpressure: stall/flush driven directly from the stimulus.
module tb_write_back_regfile;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  write_back_regfile_if #(.XLEN(64), .AW(5)) bus ();
  write_back_regfile #(.XLEN(64), .NREGS(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: architectural registers, one in-flight instruction, retire total.
  logic [63:0] m_regs [32];
  logic        p_valid;
  logic        p_we;
  logic [4:0]  p_rd;
  logic [63:0] p_data;
  logic [63:0] m_count;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    p_valid = 1'b0; p_we = 1'b0; p_rd = 5'd0; p_data = 64'd0;
    m_count = 64'd0;
  endtask

  // What decode should see for index rs given this cycle's stall/flush.
  function automatic logic [63:0] exp_read(input logic [4:0] rs, input logic st, input logic fl);
    if (rs == 5'd0) return 64'd0;
    if (BYP && p_valid && !st && !fl && p_we && p_rd == rs) return p_data;
    return m_regs[rs];
  endfunction

  // One cycle: drive at negedge, check reads mid-cycle, clock, advance model, check state.
  task automatic step(input logic iv, input logic we, input logic [4:0] rd, input logic [63:0] wd,
                      input logic st, input logic fl, input logic [4:0] r1, input logic [4:0] r2);
    bus.in_valid = iv; bus.RegWrite = we; bus.rd = rd; bus.wd = wd;
    bus.stall = st; bus.flush = fl; bus.rs1 = r1; bus.rs2 = r2;
    #1;
    chk("read_data1", bus.read_data1, exp_read(r1, st, fl));
    chk("read_data2", bus.read_data2, exp_read(r2, st, fl));
    @(posedge clk);
    if (p_valid && !st && !fl) begin
      m_count = m_count + 64'd1;
      if (p_we && p_rd != 5'd0) m_regs[p_rd] = p_data;
    end
    if (fl) p_valid = 1'b0;
    else if (!st) begin p_valid = iv; p_we = we; p_rd = rd; p_data = wd; end
    @(negedge clk);
    chk("wb_valid", {63'd0, bus.wb_valid}, {63'd0, p_valid});
    chk("retire_count", bus.retire_count, m_count);
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, r1, r2);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.RegWrite = 1'b0; bus.rd = 5'd0; bus.wd = 64'd0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.rs1 = 5'd5; bus.rs2 = 5'd31;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset wb_valid", {63'd0, bus.wb_valid}, 64'd0);
    chk("reset retire_count", bus.retire_count, 64'd0);
    chk("reset read_data1", bus.read_data1, 64'd0);
    chk("reset read_data2", bus.read_data2, 64'd0);
    rst = 1'b0;

    // 1: basic write to x5, visible after the commit edge
    step(1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 1'b0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    chk("t1 x5", bus.read_data1, 64'hDEAD_BEEF);
    chk("t1 count", bus.retire_count, 64'd1);

    // 2: write to x0 dropped but counted
    step(1'b1, 1'b1, 5'd0, 64'h1234, 1'b0, 1'b0, 5'd0, 5'd5);
    idle(5'd0, 5'd5);
    chk("t2 x0", bus.read_data1, 64'd0);
    chk("t2 count", bus.retire_count, 64'd2);

    // 3: entry held by three stall cycles, committed once after release
    step(1'b1, 1'b1, 5'd7, 64'h55, 1'b0, 1'b0, 5'd7, 5'd7);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5'd7, 64'hBAD, 1'b1, 1'b0, 5'd7, 5'd7);
    chk("t3 stalled x7", bus.read_data1, 64'd0);
    chk("t3 stalled count", bus.retire_count, 64'd2);
    idle(5'd7, 5'd0);
    chk("t3 x7", bus.read_data1, 64'h55);
    chk("t3 count", bus.retire_count, 64'd3);

    // 4: flush on the commit edge kills the entry
    step(1'b1, 1'b1, 5'd9, 64'hAA, 1'b0, 1'b0, 5'd9, 5'd0);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 5'd9, 5'd0);
    chk("t4 wb_valid", {63'd0, bus.wb_valid}, 64'd0);
    chk("t4 count", bus.retire_count, 64'd3);
    idle(5'd9, 5'd9);
    chk("t4 x9", bus.read_data1, 64'd0);

    // 5: both ports on the register being committed
    step(1'b1, 1'b1, 5'd3, 64'h77, 1'b0, 1'b0, 5'd0, 5'd0);
    bus.rs1 = 5'd3; bus.rs2 = 5'd3; bus.in_valid = 1'b0; bus.RegWrite = 1'b0;
    #1;
    chk("t5 port1 same cycle", bus.read_data1, BYP ? 64'h77 : 64'd0);
    chk("t5 port2 same cycle", bus.read_data2, BYP ? 64'h77 : 64'd0);
    idle(5'd3, 5'd3);
    chk("t5 x3", bus.read_data2, 64'h77);

    // 6: asynchronous reset between edges discards the pending x4 write
    step(1'b1, 1'b1, 5'd4, 64'h99, 1'b0, 1'b0, 5'd4, 5'd3);
    bus.in_valid = 1'b0; bus.RegWrite = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6 async wb_valid", {63'd0, bus.wb_valid}, 64'd0);
    chk("t6 async count", bus.retire_count, 64'd0);
    chk("t6 async read1", bus.read_data1, 64'd0);
    chk("t6 async read2", bus.read_data2, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(5'd4, 5'd3);
    chk("t6 x4", bus.read_data1, 64'd0);
    chk("t6 count", bus.retire_count, 64'd0);

    // Random traffic on a narrow register window to provoke back-to-back hazards
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), {$urandom, $urandom},
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int r = 0; r < 8; r++) begin
      idle(5'(r), 5'(7 - r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/write_back_regfile.md
Name: write_back_regfile

Overview:
- Write-back stage directly downstream of the memory-access stage.
- Registers the memory stage's result (wd, RegWrite, rd) in a one-deep MEM/WB stage register.
- Commits the result into a 32 x 64-bit integer register file on the following edge, then counts retired instructions.
- Provides two combinational read ports to the decode stage, with optional same-cycle bypass of the pending write.

Parameters:
- XLEN, 64, data width of registers and write data.
- NREGS, 32, number of architectural registers; index width is log2(NREGS) = 5.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  memory stage presents a valid instruction this cycle.
- RegWrite  input  1  instruction writes a destination register.
- rd  input  5  destination register index.
- wd  input  XLEN  write-back data (MemtoReg-selected output of memory stage).
- stall  input  1  hold the MEM/WB register and suppress commit.
- flush  input  1  invalidate the MEM/WB register.
- rs1  input  5  read port 1 index.
- rs2  input  5  read port 2 index.
- read_data1  output  XLEN  register rs1 contents, combinational.
- read_data2  output  XLEN  register rs2 contents, combinational.
- wb_valid  output  1  MEM/WB register holds a valid instruction.
- retire_count  output  64  number of committed instructions.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - all registers x0..x31 = 0;
  - wb_valid = 0, stored wb_regwrite = 0, wb_rd = 0, wb_data = 0;
  - retire_count = 0;
  - read_data1 and read_data2 therefore read 0.
- Reset asserted mid-operation discards the pending MEM/WB contents; no commit occurs on that edge.
- MEM/WB register, updated on each rising edge, with priority flush > stall > load:
  - flush=1: wb_valid <= 0; other fields don't-care.
  - stall=1 (flush=0): all fields hold.
  - otherwise: wb_valid <= in_valid; wb_regwrite <= RegWrite; wb_rd <= rd; wb_data <= wd.
- Commit, on the same edge, using the current MEM/WB contents:
  - Commit condition: wb_valid=1 and stall=0 and flush=0.
  - On commit: retire_count <= retire_count + 1, wrapping from 2^64-1 to 0.
  - On commit with wb_regwrite=1 and wb_rd != 0: reg[wb_rd] <= wb_data.
  - Writes to x0 are silently dropped, but the instruction is still counted.
  - A flush in the same cycle as a valid MEM/WB entry kills that entry: no write, no count.
- Latency:
  - Value on wd at edge N is written into the register file at edge N+1, when not stalled at either edge.
  - The value is architecturally visible, without bypass, from edge N+1 onward.
- Reads:
  - read_dataK = 0 when rsK = 0.
  - Otherwise read_dataK = reg[rsK], unless the bypass feature applies.
  - Both ports may address the same register.
- No X propagation: the register file is fully reset, so all reads are defined after reset.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: if wb_valid=1, stall=0, flush=0, wb_regwrite=1, wb_rd != 0 and wb_rd == rsK, then read_dataK = wb_data (write-first; the decode stage sees the value being committed this cycle).
- Undefined: read_dataK always returns the stored register value (read-old); the hazard unit must provide one extra stall cycle for read-after-write distance 1.

Test Plan:
1. Reset → RegWrite=1, rd=5, wd=0xDEAD_BEEF, in_valid=1 for one cycle; rs1=5 → read_data1=0 before edge N+1, 0xDEAD_BEEF after edge N+1; retire_count=1.
2. Write rd=0, wd=0x1234 with RegWrite=1 → rs1=0 reads 0; retire_count increments by 1.
3. Entry valid for rd=7, wd=0x55; assert stall for 3 cycles, then release → no write and no count during stall; reg[7]=0x55 one edge after release; retire_count increments by exactly 1.
4. Entry valid for rd=9, wd=0xAA with flush=1 on the commit edge → reg[9] unchanged (0); retire_count unchanged; wb_valid=0.
5. rs1=rs2=3 while MEM/WB holds rd=3, wd=0x77 → with WB_BYPASS_EN both ports read 0x77 in that cycle; without it both read the old value 0 until the next edge.
6. Assert rst asynchronously between edges while MEM/WB holds rd=4, wd=0x99 → all outputs 0 immediately; reg[4]=0 after rst is released; retire_count=0.
